rv_lsu: RTL and testbench

- Load/store unit: the execute-stage neighbour directly downstream of the ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Performs one aligned word-bus transaction per request, with byte-enable generation and load sign/zero extension.
- Returns the load result or an error to the core's writeback mux; multi-cycle, the core stalls on req_ready.

---
 rtl/rv_lsu_pkg.sv | 27 ++
 rtl/rv_lsu_align.sv | 72 +++++++
 rtl/rv_lsu.sv | 189 ++++++++++++++++++
 tb/tb_rv_lsu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, error codes and FSM states.
package rv_lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    // Response error codes
    localparam logic [1:0] LSU_OK       = 2'b00;
    localparam logic [1:0] LSU_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_ILLEGAL  = 2'b10;
    localparam logic [1:0] LSU_TIMEOUT  = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication, load
// extraction/extension and legality classification of one access.
module rv_lsu_align
    import rv_lsu_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [31:0] w_rshift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection of the returned bus word
    always_comb begin
        w_rshift = i_rdata >> {i_addr_lo, 3'b000};
        w_byte   = w_rshift[7:0];
        w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Decode funct3 into enables, data formatting and error flags
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'h0;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            LSU_LB: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            LSU_LH: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            LSU_LW: begin
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_rdata;
                o_misalign = |i_addr_lo;
            end
            LSU_LBU: begin
                // Unsigned variants exist only for loads
                o_be      = 4'b0001 << i_addr_lo;
                o_rdata   = {24'h0, w_byte};
                o_illegal = i_we;
            end
            LSU_LHU: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_rdata    = {16'h0, w_half};
                o_misalign = i_addr_lo[0];
                o_illegal  = i_we;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one op from the execute stage, runs a single aligned
// word-bus access (or reports an error without touching the bus) and returns a
// one-cycle response to writeback.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so the core holds req_valid until accepted.
// The bus side keeps mem_req and its qualifiers stable until mem_ack is sampled
// high on a rising edge or the timeout expires.
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [15:0] r_cnt;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_resp_rdata;
    logic [1:0]  r_resp_err;

    logic        w_idle;
    logic        w_accept;
    logic        w_timeout;
    logic        w_sel_we;
    logic [2:0]  w_sel_funct3;
    logic [1:0]  w_sel_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_rdata_ext;
    logic        w_misalign;
    logic        w_illegal;

    // Classify the incoming request in IDLE, otherwise format the latched op
    always_comb begin
        w_idle        = (r_state == ST_IDLE);
        w_accept      = w_idle && req_valid;
        w_timeout     = (r_state == ST_WAIT) && !mem_ack && (r_cnt == TIMEOUT_LAST);
        w_sel_we      = w_idle ? req_we         : r_we;
        w_sel_funct3  = w_idle ? req_funct3     : r_funct3;
        w_sel_addr_lo = w_idle ? req_addr[1:0]  : r_addr_lo;
    end

    rv_lsu_align u_align (
        .i_we       (w_sel_we),
        .i_funct3   (w_sel_funct3),
        .i_addr_lo  (w_sel_addr_lo),
        .i_wdata    (req_wdata),
        .i_rdata    (mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_next = (w_illegal || w_misalign) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latches, bus qualifiers, timeout counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_cnt        <= 16'h0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'h0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= LSU_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 16'h0;
                    if (w_accept) begin
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        // Illegal funct3 outranks misalignment
                        if (w_illegal) begin
                            r_resp_err   <= LSU_ILLEGAL;
                            r_resp_rdata <= 32'h0;
                        end else if (w_misalign) begin
                            r_resp_err   <= LSU_MISALIGN;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_mem_we    <= req_we;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= req_we ? w_wdata_sh : 32'h0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack || w_timeout) begin
                        // An ack in the timeout cycle still completes normally
                        r_resp_err   <= mem_ack ? LSU_OK : LSU_TIMEOUT;
                        r_resp_rdata <= (mem_ack && !r_we) ? w_rdata_ext : 32'h0;
                        r_cnt        <= 16'h0;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= 32'h0;
                        r_mem_be     <= 4'b0000;
                        r_mem_wdata  <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 16'h1;
                    end
                end
                default: begin
                    r_cnt <= 16'h0;
                end
            endcase
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu with a short timeout so the expiry path is cheap to reach.
module tb_rv_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    rv_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something wedges
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver: present one request, return #1 after the accepting edge
    task automatic send_req(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_tests++; if (resp_valid !== 1'b0 || resp_err !== 2'b00 || resp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_resp: got v=%b e=%b d=%h want 0/00/0", resp_valid, resp_err, resp_rdata); end
        n_tests++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus: got a=%h be=%b wd=%h we=%b want zeros", mem_addr, mem_be, mem_wdata, mem_we); end
        n_tests++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", dbg_state); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        send_req(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        n_tests++; if (mem_req !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL sw_req: got req=%b ready=%b want 1/0", mem_req, req_ready); end
        n_tests++; if (mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL sw_bus: got a=%h be=%b wd=%h we=%b want 100/1111/deadbeef/1", mem_addr, mem_be, mem_wdata, mem_we); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_stable: got req=%b a=%h wd=%h", mem_req, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_tests++; if (resp_valid !== 1'b1 || resp_err !== 2'b00 || resp_rdata !== 32'h0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL sw_resp: got v=%b e=%b d=%h req=%b want 1/00/0/0", resp_valid, resp_err, resp_rdata, mem_req); end
        @(posedge clk); #1;
        n_tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL sw_done: got v=%b ready=%b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_load_byte();
        // LB at byte lane 3, ack on first WAIT cycle
        send_req(1'b0, 3'b000, 32'h0000_0203, 32'h0);
        n_tests++; if (mem_be !== 4'b1000 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL lb_bus: got be=%b a=%h we=%b want 1000/200/0", mem_be, mem_addr, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'h80FF_7F01;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80 || resp_err !== 2'b00) begin
            n_fail++; $display("FAIL lb_resp: got v=%b d=%h e=%b want 1/ffffff80/00", resp_valid, resp_rdata, resp_err); end
        @(posedge clk); #1;
        n_tests++; if (resp_rdata !== 32'hFFFF_FF80 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL lb_hold: got v=%b d=%h want 0/ffffff80", resp_valid, resp_rdata); end
        // LBU same address
        send_req(1'b0, 3'b100, 32'h0000_0203, 32'h0);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080) begin
            n_fail++; $display("FAIL lbu_resp: got v=%b d=%h want 1/00000080", resp_valid, resp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_halfword();
        send_req(1'b0, 3'b001, 32'h0000_0302, 32'h0);
        n_tests++; if (mem_be !== 4'b1100 || mem_addr !== 32'h300) begin
            n_fail++; $display("FAIL lh_bus: got be=%b a=%h want 1100/300", mem_be, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_8001) begin
            n_fail++; $display("FAIL lh_resp: got v=%b d=%h want 1/ffff8001", resp_valid, resp_rdata); end
        @(posedge clk); #1;
        // LHU lower half of 0xF00D_9ABC
        send_req(1'b0, 3'b101, 32'h0000_0300, 32'h0);
        n_tests++; if (mem_be !== 4'b0011) begin n_fail++; $display("FAIL lhu_be: got %b want 0011", mem_be); end
        mem_ack = 1'b1; mem_rdata = 32'hF00D_9ABC;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_tests++; if (resp_rdata !== 32'h0000_9ABC) begin n_fail++; $display("FAIL lhu_resp: got %h want 00009abc", resp_rdata); end
        @(posedge clk); #1;
        // SB lane 1 and SH upper half replicate data
        send_req(1'b1, 3'b000, 32'h0000_0101, 32'h1234_56AB);
        n_tests++; if (mem_be !== 4'b0010 || mem_wdata !== 32'hABAB_ABAB) begin
            n_fail++; $display("FAIL sb_bus: got be=%b wd=%h want 0010/abababab", mem_be, mem_wdata); end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        send_req(1'b1, 3'b001, 32'h0000_0102, 32'hFFFF_1234);
        n_tests++; if (mem_be !== 4'b1100 || mem_wdata !== 32'h1234_1234) begin
            n_fail++; $display("FAIL sh_bus: got be=%b wd=%h want 1100/12341234", mem_be, mem_wdata); end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        // Misaligned SH: straight to response, bus untouched
        send_req(1'b1, 3'b001, 32'h0000_0301, 32'h0);
        n_tests++; if (mem_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 2'b01 || resp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sh_misalign: got req=%b v=%b e=%b d=%h want 0/1/01/0", mem_req, resp_valid, resp_err, resp_rdata); end
        @(posedge clk); #1;
        // Misaligned LW
        send_req(1'b0, 3'b010, 32'h0000_0402, 32'h0);
        n_tests++; if (mem_req !== 1'b0 || resp_err !== 2'b01) begin
            n_fail++; $display("FAIL lw_misalign: got req=%b e=%b want 0/01", mem_req, resp_err); end
        @(posedge clk); #1;
        // Illegal load funct3
        send_req(1'b0, 3'b011, 32'h0000_0000, 32'h0);
        n_tests++; if (mem_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 2'b10) begin
            n_fail++; $display("FAIL ld_illegal: got req=%b v=%b e=%b want 0/1/10", mem_req, resp_valid, resp_err); end
        @(posedge clk); #1;
        // Illegal beats misaligned
        send_req(1'b1, 3'b011, 32'h0000_0001, 32'h0);
        n_tests++; if (resp_err !== 2'b10) begin n_fail++; $display("FAIL st_illegal_prio: got %b want 10", resp_err); end
        @(posedge clk); #1;
        // Unsigned-style funct3 is illegal for stores
        send_req(1'b1, 3'b100, 32'h0000_0000, 32'h0);
        n_tests++; if (resp_err !== 2'b10 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL st_f3_100: got e=%b req=%b want 10/0", resp_err, mem_req); end
        @(posedge clk); #1;
        n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_done: got ready=%b v=%b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        bit done;
        req_cycles = 0;
        done = 1'b0;
        send_req(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 12 && !done; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (resp_valid === 1'b1) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL to_resp: got no resp_valid want resp within 12 cycles"); end
        n_tests++; if (req_cycles != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
        n_tests++; if (resp_err !== 2'b11 || resp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_err: got e=%b d=%h want 11/0", resp_err, resp_rdata); end
        @(posedge clk); #1;
        // Ack on the 4th WAIT cycle beats the timeout
        send_req(1'b0, 3'b010, 32'h0000_0504, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL to_4th_req: got %b want 1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_tests++; if (resp_valid !== 1'b1 || resp_err !== 2'b00 || resp_rdata !== 32'h1357_9BDF) begin
            n_fail++; $display("FAIL to_ack_wins: got v=%b e=%b d=%h want 1/00/13579bdf", resp_valid, resp_err, resp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        send_req(1'b0, 3'b010, 32'h0000_0600, 32'h0);
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %b want 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_async: got req=%b ready=%b want 0/1", mem_req, req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_noresp: got %0d resp pulses want 0", seen); end
        // Fresh LW after reset completes normally
        send_req(1'b0, 3'b010, 32'h0000_0700, 32'h0);
        n_tests++; if (mem_addr !== 32'h700 || mem_be !== 4'b1111) begin
            n_fail++; $display("FAIL rst_lw_bus: got a=%h be=%b want 700/1111", mem_addr, mem_be); end
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D || resp_err !== 2'b00) begin
            n_fail++; $display("FAIL rst_lw_resp: got v=%b d=%h e=%b want 1/cafef00d/00", resp_valid, resp_rdata, resp_err); end
        @(posedge clk); #1;
    endtask

    initial begin
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_halfword();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
